// File: rtl/fetch_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : fetch_branch_predictor
// Purpose  : Fetch-stage dynamic branch predictor. A table of 2-bit
//            saturating counters is indexed from the fetch PC. The
//            prediction is registered one cycle after lookup, and the table
//            is trained from branches resolved in execute.
// Options  : BR_PRED_GSHARE_EN - XOR the lookup index with a global history
//            register (gshare). When undefined, the predictor is bimodal.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_branch_predictor #(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_vld,
  input  logic [31:0]      fetch_pc,
  input  logic             flush,
  output logic             pred_vld,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_vld,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]       ctr [ENTRIES];
  logic [IDX_W-1:0] lkp_idx;
  logic [1:0]       upd_cur;
  logic [1:0]       upd_next;

  // Word-offset and high PC bits never take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0]};

`ifdef BR_PRED_GSHARE_EN
  logic [IDX_W-1:0] ghr;

  // Global history shifts only at resolve, so it is never speculative.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ghr <= '0;
    else if (upd_vld)
      ghr <= {ghr[IDX_W-2:0], upd_taken};
  end

  // The lookup uses the history as it was before any same-cycle shift.
  assign lkp_idx = fetch_pc[IDX_W+1:2] ^ ghr;
`else
  assign lkp_idx = fetch_pc[IDX_W+1:2];
`endif

  // Saturating increment/decrement of the counter being trained.
  always_comb begin
    upd_cur  = ctr[upd_idx];
    upd_next = upd_cur;
    if (upd_taken) begin
      if (upd_cur != 2'b11) upd_next = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_next = upd_cur - 2'b01;
    end
  end

  // Counter table: resets to weakly not-taken and trains on every resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (upd_vld) begin
      ctr[upd_idx] <= upd_next;
    end
  end

  // Registered prediction. It reads the pre-update counter, with no bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_vld   <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
    end else begin
      pred_vld <= fetch_vld & ~flush;
      if (fetch_vld) begin
        pred_taken <= ctr[lkp_idx][1];
        pred_idx   <= lkp_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_branch_predictor
// Purpose  : Directed, table-driven bench for fetch_branch_predictor. The
//            bimodal table runs by default. Defining BR_PRED_GSHARE_EN
//            switches to the global-history sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_vld;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        pred_vld;
  logic        pred_taken;
  logic [5:0]  pred_idx;
  logic        upd_vld;
  logic [5:0]  upd_idx;
  logic        upd_taken;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic        fl;
    logic        uv;
    logic [5:0]  ui;
    logic        ut;
    logic        chk_data;
    logic        ev;
    logic        et;
    logic [5:0]  ei;
  } vec_t;

  vec_t vecs [16];

  fetch_branch_predictor #(.IDX_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_vld  (fetch_vld),
    .fetch_pc   (fetch_pc),
    .flush      (flush),
    .pred_vld   (pred_vld),
    .pred_taken (pred_taken),
    .pred_idx   (pred_idx),
    .upd_vld    (upd_vld),
    .upd_idx    (upd_idx),
    .upd_taken  (upd_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fv, input logic [31:0] pc, input logic fl,
                              input logic uv, input logic [5:0] ui, input logic ut,
                              input logic cd, input logic ev, input logic et,
                              input logic [5:0] ei);
    vec_t v;
    v.fv = fv; v.pc = pc; v.fl = fl; v.uv = uv; v.ui = ui; v.ut = ut;
    v.chk_data = cd; v.ev = ev; v.et = et; v.ei = ei;
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic drive(input logic fv, input logic [31:0] pc, input logic fl,
                       input logic uv, input logic [5:0] ui, input logic ut);
    @(negedge clk);
    fetch_vld = fv; fetch_pc = pc; flush = fl;
    upd_vld = uv; upd_idx = ui; upd_taken = ut;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 6'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; fetch_vld = 1'b0; fetch_pc = '0; flush = 1'b0;
    upd_vld = 1'b0; upd_idx = '0; upd_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pred_vld", {31'd0, pred_vld}, 32'd0);
    check("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("reset_pred_idx", {26'd0, pred_idx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

`ifndef BR_PRED_GSHARE_EN
    //            fv   pc        fl   uv   ui    ut   cd   ev   et   ei
    vecs[0]  = mk(1'b1, 32'h100, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
    vecs[1]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 6'd5, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
    vecs[2]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 6'd5, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
    vecs[3]  = mk(1'b1, 32'h14,  1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd5);
    vecs[4]  = mk(1'b0, 32'h0,   1'b0, 1'b1, 6'd5, 1'b1, 1'b1, 1'b0, 1'b1, 6'd5);
    vecs[5]  = mk(1'b1, 32'h14,  1'b0, 1'b1, 6'd5, 1'b0, 1'b1, 1'b1, 1'b1, 6'd5);
    vecs[6]  = mk(1'b1, 32'h14,  1'b0, 1'b1, 6'd5, 1'b0, 1'b1, 1'b1, 1'b1, 6'd5);
    vecs[7]  = mk(1'b1, 32'h14,  1'b0, 1'b1, 6'd5, 1'b0, 1'b1, 1'b1, 1'b0, 6'd5);
    vecs[8]  = mk(1'b1, 32'h14,  1'b0, 1'b1, 6'd5, 1'b0, 1'b1, 1'b1, 1'b0, 6'd5);
    vecs[9]  = mk(1'b1, 32'h14,  1'b0, 1'b1, 6'd5, 1'b1, 1'b1, 1'b1, 1'b0, 6'd5);
    vecs[10] = mk(1'b1, 32'h14,  1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd5);
    vecs[11] = mk(1'b1, 32'h0C,  1'b0, 1'b1, 6'd3, 1'b1, 1'b1, 1'b1, 1'b0, 6'd3);
    vecs[12] = mk(1'b1, 32'h0C,  1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd3);
    vecs[13] = mk(1'b1, 32'h100, 1'b1, 1'b1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    vecs[14] = mk(1'b1, 32'h1C,  1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd7);
    vecs[15] = mk(1'b0, 32'h1C,  1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd7);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].fv, vecs[i].pc, vecs[i].fl, vecs[i].uv, vecs[i].ui, vecs[i].ut);
      check($sformatf("vec%0d_pred_vld", i), {31'd0, pred_vld}, {31'd0, vecs[i].ev});
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d_pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].et});
        check($sformatf("vec%0d_pred_idx", i), {26'd0, pred_idx}, {26'd0, vecs[i].ei});
      end
    end

    // Reset in the middle of a cycle, with counter 9 strongly taken and a valid prediction out.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 6'd9, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 6'd9, 1'b1);
    drive(1'b1, 32'h24, 1'b0, 1'b0, 6'd0, 1'b0);
    check("pre_rst_pred_vld", {31'd0, pred_vld}, 32'd1);
    check("pre_rst_pred_taken", {31'd0, pred_taken}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_pred_vld", {31'd0, pred_vld}, 32'd0);
    check("async_rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("async_rst_pred_idx", {26'd0, pred_idx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32'h24, 1'b0, 1'b0, 6'd0, 1'b0);
    check("post_rst_pred_vld", {31'd0, pred_vld}, 32'd1);
    check("post_rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("post_rst_pred_idx", {26'd0, pred_idx}, 32'd9);
`else
    // History T, T, N gives ghr = 3'b110. The lookup in the same cycle as the last shift still uses ghr = 3'b011.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 6'h3F, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 6'h3F, 1'b1);
    drive(1'b1, 32'h08, 1'b0, 1'b1, 6'h3F, 1'b0);
    check("gs_same_cycle_idx", {26'd0, pred_idx}, 32'h01);
    check("gs_same_cycle_vld", {31'd0, pred_vld}, 32'd1);
    drive(1'b1, 32'h08, 1'b0, 1'b0, 6'd0, 1'b0);
    check("gs_idx", {26'd0, pred_idx}, 32'h04);
    check("gs_taken", {31'd0, pred_taken}, 32'd0);
    // Train entry 4 to taken. Two taken updates also shift ghr to 6'b011011.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 6'h04, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 6'h04, 1'b1);
    drive(1'b1, 32'h08, 1'b0, 1'b0, 6'd0, 1'b0);
    check("gs_idx2", {26'd0, pred_idx}, 32'h19);
    check("gs_taken2", {31'd0, pred_taken}, 32'd0);
    // PC 0x74 has index 0x1D, and 0x1D ^ 0x1B = 0x06. Entry 6 is untouched.
    drive(1'b1, 32'h74, 1'b0, 1'b0, 6'd0, 1'b0);
    check("gs_idx3", {26'd0, pred_idx}, 32'h06);
    // PC 0x7C has index 0x1F, and 0x1F ^ 0x1B = 0x04. Entry 4 is now 2'b11.
    drive(1'b1, 32'h7C, 1'b0, 1'b0, 6'd0, 1'b0);
    check("gs_idx4", {26'd0, pred_idx}, 32'h04);
    check("gs_taken4", {31'd0, pred_taken}, 32'd1);
    idle();
    check("gs_idle_vld", {31'd0, pred_vld}, 32'd0);
    check("gs_idle_hold_idx", {26'd0, pred_idx}, 32'h04);
    check("gs_idle_hold_taken", {31'd0, pred_taken}, 32'd1);
    drive(1'b1, 32'h7C, 1'b1, 1'b0, 6'd0, 1'b0);
    check("gs_flush_vld", {31'd0, pred_vld}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_branch_predictor.md
# fetch_branch_predictor

Dynamic conditional-branch predictor in the fetch stage. It produces the `br_pred` bit that travels with each instruction down to execute, where the branch-flush logic compares it against the resolved outcome. The block holds a table of 2-bit saturating counters indexed from the fetch PC, returns a registered prediction one cycle after lookup, and trains the table from resolved branches reported by execute.

## Interface
Parameters:
- `IDX_W`, default 6: table index width; the table holds 2^IDX_W counters.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fetch_vld`  in  1  lookup request this cycle.
- `fetch_pc`  in  32  PC of the fetched instruction; bits [1:0] are ignored.
- `flush`  in  1  pipeline flush from execute; squashes the pending lookup.
- `pred_vld`  out  1  prediction valid, registered.
- `pred_taken`  out  1  predicted taken; this is the `br_pred` carried down the pipe.
- `pred_idx`  out  IDX_W  table index used for the lookup; carried down the pipe alongside the instruction.
- `upd_vld`  in  1  a conditional branch resolved in execute.
- `upd_idx`  in  IDX_W  `pred_idx` that was carried with that branch.
- `upd_taken`  in  1  resolved direction.

## Operation
- Table: 2^IDX_W entries of 2-bit counters, implemented as flops.
  - Every entry resets to 2'b01 (weakly not-taken).
  - The prediction is counter bit [1] (2'b10 and 2'b11 predict taken).
- Lookup index: `fetch_pc[IDX_W+1:2]`. With `BR_PRED_GSHARE_EN`, this value is XORed with `ghr`.
- Lookup:
  - Registers `pred_taken`, `pred_idx` and `pred_vld = fetch_vld & ~flush`.
  - When `fetch_vld` = 0, `pred_taken` and `pred_idx` hold their last values.
- Update, when `upd_vld` = 1, applied to entry `upd_idx`:
  - `upd_taken` = 1: counter += 1, saturating at 2'b11.
  - `upd_taken` = 0: counter -= 1, saturating at 2'b00.
  - Updates are unconditional; a correct prediction still trains the counter.
- Lookup and update in the same cycle to the same index:
  - The lookup returns the pre-update counter value. There is no bypass.
  - The update still commits.
- `flush` does not block an update in the same cycle; the resolving branch always trains.
- Reset mid-operation: all counters, `pred_vld`, `pred_taken` and `pred_idx` clear immediately (counters to 2'b01, the outputs to 0). Any pending lookup is lost.

## Timing
- Lookup latency: 1 cycle. `fetch_vld` at cycle N gives `pred_*` valid at cycle N+1.
- Update latency: 1 cycle. A write at the edge ending cycle N is visible to a lookup issued in cycle N+1.
- Throughput: one lookup and one update per cycle, with no stalls and no backpressure.
- Reset values:
  - `pred_vld` = 0, `pred_taken` = 0, `pred_idx` = 0.
  - Counters = 2'b01; `ghr` = 0.
- `flush` asserted in cycle N forces `pred_vld` = 0 in cycle N+1 regardless of `fetch_vld`.

## Configuration
- `BR_PRED_GSHARE_EN` defined:
  - Adds an IDX_W-bit global history register `ghr`, reset to 0.
  - On `upd_vld`: `ghr <= {ghr[IDX_W-2:0], upd_taken}`. History is non-speculative, updated at resolve only.
  - Lookup index = `fetch_pc[IDX_W+1:2] ^ ghr`, using the `ghr` value before any same-cycle shift.
- Not defined:
  - No `ghr` flops.
  - Index = `fetch_pc[IDX_W+1:2]` (bimodal predictor).
  - Ports are identical in both builds.

## Test plan
- Reset, then lookup PC 0x100 with `fetch_vld` = 1 → next cycle `pred_vld` = 1, `pred_taken` = 0, `pred_idx` = 0x00.
- Two updates to idx 5 with taken = 1, then lookup PC 0x14 → `pred_taken` = 1. A third taken update followed by three not-taken updates gives counter 2'b00; the counter must not wrap.
- Same-cycle update of idx 3 (01→10) and lookup of PC 0x0C → `pred_taken` = 0. A repeat lookup the following cycle → `pred_taken` = 1.
- `fetch_vld` = 1 with `flush` = 1 in the same cycle → `pred_vld` = 0 next cycle. A concurrent update to idx 7 still commits.
- Assert `rst` while counter 9 = 2'b11 and `pred_vld` = 1 → outputs clear immediately. A later lookup of PC 0x24 → `pred_taken` = 0.
- With `BR_PRED_GSHARE_EN`, updates T, T, N give `ghr` = 0b110. A lookup of PC 0x08 then reports `pred_idx` = 0x02 ^ 0x06 = 0x04.
